perf_monitor: RTL and testbench

PERF_MONITOR -- requirements
Module: perf_monitor

---
 rtl/perf_pkg.sv | 18 +
 rtl/sat_counter.sv | 34 +++
 rtl/perf_monitor.sv | 125 ++++++++++++
 tb/tb_perf_monitor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// perf_pkg: shared definitions for the performance monitor.
//   perf_state_e : measurement FSM state encoding (RUN=0, HALTED=1, TIMED_OUT=2)
//   SEL_CYCLE    : rd_sel index of the cycle counter
//   SEL_INSTR    : rd_sel index of the retired-instruction counter
//   SEL_EV_BASE  : rd_sel index of event channel 0 (channel i is at SEL_EV_BASE+i)
package perf_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALTED    = 2'd1,
    ST_TIMED_OUT = 2'd2
  } perf_state_e;

  localparam int SEL_CYCLE   = 0;
  localparam int SEL_INSTR   = 1;
  localparam int SEL_EV_BASE = 2;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with a sticky overflow flag.
//   clk    in  clock
//   rst_n  in  async active-low reset, zeroes value and ovf
//   clr    in  synchronous zero of value and ovf (wins over hold)
//   hold   in  freeze value and ovf
//   inc    in  count request for this edge
//   value  out counter value, stops at all-ones
//   ovf    out set on the edge the counter would have wrapped
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hold,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (!hold && inc) begin
      if (&value) ovf <= 1'b1;
      else        value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: cycle / retired-instruction / event counters with a
// run-halt-timeout measurement FSM and a registered read port.
//   clk     in  clock
//   rst_n   in  async active-low reset
//   clear   in  synchronous restart (zero counters, back to RUN)
//   is_halt in  processor halt indication, ends the measurement
//   w_v     in  writeback valid, one retired instruction per high cycle
//   ev      in  per-channel event strobes
//   rd_sel  in  read index: 0 cycles, 1 instructions, 2+i event channel i
//   rd_data out registered counter value of rd_sel (0 if out of range)
//   rd_ovf  out registered sticky overflow of rd_sel (0 if out of range)
//   cycle   out live cycle counter
//   instrs  out live instruction counter
//   state   out FSM state
//   done    out state is HALTED or TIMED_OUT
//
// state     | meaning
// RUN       | counting; halt or timeout ends the measurement
// HALTED    | is_halt seen; counters frozen until clear
// TIMED_OUT | cycle reached TIMEOUT; counters frozen until clear
module perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NUM_EV  = 4,
  parameter int TIMEOUT = 10000,
  localparam int RD_W   = $clog2(NUM_EV + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              is_halt,
  input  logic              w_v,
  input  logic [NUM_EV-1:0] ev,
  input  logic [RD_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic [CNT_W-1:0]  cycle,
  output logic [CNT_W-1:0]  instrs,
  output logic [1:0]        state,
  output logic              done
);

  localparam int NUM_CNT = NUM_EV + 2;
  localparam bit TO_EN   = (TIMEOUT != 0);
  // Last RUN value of the cycle counter before the timeout fires.
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  perf_state_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_val [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_vec;
  logic [NUM_CNT-1:0] inc_vec;
  logic               hold;
  logic               to_hit;
  logic [CNT_W-1:0]   rd_mux;
  logic               ovf_mux;

  // Bit order matches the rd_sel map: cycle, instrs, then event channels.
  assign inc_vec = {ev, w_v, 1'b1};
  assign hold    = (state_q != ST_RUN);
  assign to_hit  = TO_EN && (cnt_val[SEL_CYCLE] == TO_LAST);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .hold  (hold),
      .inc   (inc_vec[i]),
      .value (cnt_val[i]),
      .ovf   (ovf_vec[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Halt is tested before timeout so a coincident halt wins.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (is_halt)     state_d = ST_HALTED;
          else if (to_hit) state_d = ST_TIMED_OUT;
        end
        ST_HALTED:    state_d = ST_HALTED;
        ST_TIMED_OUT: state_d = ST_TIMED_OUT;
        default:      state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    rd_mux  = '0;
    ovf_mux = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == RD_W'(i)) begin
        rd_mux  = cnt_val[i];
        ovf_mux = ovf_vec[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else begin
      rd_data <= rd_mux;
      rd_ovf  <= ovf_mux;
    end
  end

  assign cycle  = cnt_val[SEL_CYCLE];
  assign instrs = cnt_val[SEL_INSTR];
  assign state  = state_q;
  assign done   = (state_q == ST_HALTED) || (state_q == ST_TIMED_OUT);

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed stimulus with a scoreboard queue. Each stimulus
// step pushes the values it expects; a monitor on the falling edge pops and
// compares them. A second instance with CNT_W=4 and TIMEOUT=0 covers
// saturation and the disabled timeout.
module tb_perf_monitor;

  localparam int K_CYC  = 0;
  localparam int K_INS  = 1;
  localparam int K_ST   = 2;
  localparam int K_DONE = 3;
  localparam int K_RD   = 4;
  localparam int K_OVF  = 5;
  localparam int K_SCYC = 6;
  localparam int K_SST  = 7;
  localparam int K_SRD  = 8;
  localparam int K_SOVF = 9;

  typedef struct {
    int     kind;
    longint val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        is_halt = 1'b0;
  logic        w_v = 1'b0;
  logic [3:0]  ev = '0;
  logic [2:0]  rd_sel = '0;
  logic [31:0] rd_data;
  logic        rd_ovf;
  logic [31:0] cycle;
  logic [31:0] instrs;
  logic [1:0]  state;
  logic        done;

  logic        s_clear = 1'b0;
  logic        s_is_halt = 1'b0;
  logic        s_w_v = 1'b0;
  logic [3:0]  s_ev = '0;
  logic [2:0]  s_rd_sel = '0;
  logic [3:0]  s_rd_data;
  logic        s_rd_ovf;
  logic [3:0]  s_cycle;
  logic [3:0]  s_instrs;
  logic [1:0]  s_state;
  logic        s_done;

  always #5 clk = ~clk;

  perf_monitor #(.CNT_W(32), .NUM_EV(4), .TIMEOUT(10000)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .is_halt(is_halt), .w_v(w_v),
    .ev(ev), .rd_sel(rd_sel), .rd_data(rd_data), .rd_ovf(rd_ovf),
    .cycle(cycle), .instrs(instrs), .state(state), .done(done)
  );

  perf_monitor #(.CNT_W(4), .NUM_EV(4), .TIMEOUT(0)) dut_small (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .is_halt(s_is_halt), .w_v(s_w_v),
    .ev(s_ev), .rd_sel(s_rd_sel), .rd_data(s_rd_data), .rd_ovf(s_rd_ovf),
    .cycle(s_cycle), .instrs(s_instrs), .state(s_state), .done(s_done)
  );

  function automatic string kind_name(input int k);
    case (k)
      K_CYC:   return "cycle";
      K_INS:   return "instrs";
      K_ST:    return "state";
      K_DONE:  return "done";
      K_RD:    return "rd_data";
      K_OVF:   return "rd_ovf";
      K_SCYC:  return "small.cycle";
      K_SST:   return "small.state";
      K_SRD:   return "small.rd_data";
      K_SOVF:  return "small.rd_ovf";
      default: return "unknown";
    endcase
  endfunction

  function automatic longint observe(input int k);
    case (k)
      K_CYC:   return longint'(cycle);
      K_INS:   return longint'(instrs);
      K_ST:    return longint'(state);
      K_DONE:  return longint'(done);
      K_RD:    return longint'(rd_data);
      K_OVF:   return longint'(rd_ovf);
      K_SCYC:  return longint'(s_cycle);
      K_SST:   return longint'(s_state);
      K_SRD:   return longint'(s_rd_data);
      K_SOVF:  return longint'(s_rd_ovf);
      default: return -1;
    endcase
  endfunction

  task automatic expect_val(input int kind, input longint val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: everything queued since the last falling edge is compared here.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        longint act;
        e = sb.pop_front();
        act = observe(e.kind);
        checks++;
        if (act != e.val) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d at %0t", kind_name(e.kind), act, e.val, $time);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] w_pat;
    longint      sweep_exp [8];

    // Reset state
    step(1);
    expect_val(K_CYC, 0);
    expect_val(K_INS, 0);
    expect_val(K_ST, 0);
    expect_val(K_DONE, 0);
    expect_val(K_RD, 0);
    expect_val(K_OVF, 0);
    step(1);

    // 20 cycles, w_v on 7 of the first 19 plus the halting cycle
    w_pat = '0;
    w_pat[1] = 1'b1; w_pat[3] = 1'b1; w_pat[6] = 1'b1; w_pat[9] = 1'b1;
    w_pat[12] = 1'b1; w_pat[14] = 1'b1; w_pat[17] = 1'b1; w_pat[19] = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      w_v     = w_pat[k];
      is_halt = (k == 19);
      ev      = (k < 5) ? 4'b0101 : 4'b0000;
      step(1);
    end
    w_v = 1'b0; is_halt = 1'b0; ev = '0;
    expect_val(K_CYC, 20);
    expect_val(K_INS, 8);
    expect_val(K_ST, 1);
    expect_val(K_DONE, 1);

    // HALTED ignores all inputs
    w_v = 1'b1; ev = 4'b1111; is_halt = 1'b1;
    step(3);
    expect_val(K_CYC, 20);
    expect_val(K_INS, 8);
    expect_val(K_ST, 1);
    w_v = 1'b0; ev = '0; is_halt = 1'b0;

    // Read sweep, one new index per cycle, including out-of-range 6 and 7
    sweep_exp = '{20, 8, 5, 0, 5, 0, 0, 0};
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      step(1);
      expect_val(K_RD, sweep_exp[s]);
      expect_val(K_OVF, 0);
    end

    // Clear overrides is_halt and restarts counting
    rd_sel = 3'd2;
    clear = 1'b1; is_halt = 1'b1; w_v = 1'b1; ev = 4'b1111;
    step(1);
    expect_val(K_CYC, 0);
    expect_val(K_INS, 0);
    expect_val(K_ST, 0);
    expect_val(K_DONE, 0);
    expect_val(K_RD, 5);
    clear = 1'b0; is_halt = 1'b0;
    step(3);
    expect_val(K_CYC, 3);
    expect_val(K_INS, 3);
    expect_val(K_RD, 2);
    w_v = 1'b0; ev = '0;

    // Async reset pulsed between edges at cycle 50
    step(46);
    expect_val(K_CYC, 49);
    step(1);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    expect_val(K_CYC, 0);
    expect_val(K_INS, 0);
    expect_val(K_ST, 0);
    expect_val(K_RD, 0);
    step(1);
    expect_val(K_CYC, 1);
    expect_val(K_ST, 0);

    // Timeout freezes cycle at 10000
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(9998);
    expect_val(K_CYC, 9998);
    expect_val(K_ST, 0);
    step(1);
    expect_val(K_CYC, 9999);
    expect_val(K_ST, 0);
    step(1);
    expect_val(K_CYC, 10000);
    expect_val(K_ST, 2);
    expect_val(K_DONE, 1);
    is_halt = 1'b1; w_v = 1'b1;
    step(3);
    expect_val(K_CYC, 10000);
    expect_val(K_INS, 0);
    expect_val(K_ST, 2);
    is_halt = 1'b0; w_v = 1'b0;

    // Halt on the timeout edge wins
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(9999);
    expect_val(K_CYC, 9999);
    is_halt = 1'b1;
    step(1);
    is_halt = 1'b0;
    expect_val(K_CYC, 10000);
    expect_val(K_ST, 1);
    expect_val(K_DONE, 1);

    // 4-bit instance: ev[0] 15 cycles (no overflow), ev[1] 20 cycles (overflow)
    s_clear = 1'b1;
    step(1);
    s_clear = 1'b0;
    s_ev = 4'b0011;
    step(15);
    s_ev = 4'b0010;
    step(5);
    s_ev = 4'b0000;
    s_rd_sel = 3'd3;
    step(1);
    expect_val(K_SRD, 15);
    expect_val(K_SOVF, 1);
    s_rd_sel = 3'd2;
    step(1);
    expect_val(K_SRD, 15);
    expect_val(K_SOVF, 0);
    s_rd_sel = 3'd4;
    step(1);
    expect_val(K_SRD, 0);
    expect_val(K_SOVF, 0);
    s_rd_sel = 3'd0;
    step(1);
    expect_val(K_SRD, 15);
    expect_val(K_SOVF, 1);
    expect_val(K_SCYC, 15);
    expect_val(K_SST, 0);

    step(2);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
